// File: rtl/adc_frame_pkg.sv
// Shared types, default sizes and the frame-length clamp for the ADC frame sequencer.
package adc_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RECV  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int MAX_BITS_DEF    = 1024;
    localparam int CNT_W_DEF       = 11;
    localparam int ERR_CNT_W_DEF   = 8;
    localparam int TIMEOUT_CYC_DEF = 4096;

    // A zero or oversized request means "fill the whole buffer".
    function automatic int clamp_len(input int cfg, input int max_bits);
        if (cfg == 0 || cfg > max_bits) begin
            return max_bits;
        end
        return cfg;
    endfunction

endpackage

// File: rtl/adc_frame_seq_sat_counter.sv
// Saturating event counter; holds at all-ones until reset.
module sat_counter
    import adc_frame_pkg::*;
#(
    parameter int WIDTH = ERR_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (inc && (q_q != '1)) begin
            q_d = q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/adc_frame_seq.sv
// Frame sequencer for the ADC shift/double-buffer path: clear, gate bits, count, capture,
// then track the consumer handshake and error events.
module adc_frame_seq
    import adc_frame_pkg::*;
#(
    parameter int MAX_BITS    = MAX_BITS_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int ERR_CNT_W   = ERR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 trigger,
    input  logic [CNT_W-1:0]     cfg_frame_bits,
    input  logic                 rx_bit_valid_in,
    input  logic                 rx_bit_in,
    input  logic                 frame_ack,
    output logic                 start,
    output logic                 rx_bit_valid,
    output logic                 rx_bit,
    output logic                 pkt_done,
    output logic                 busy,
    output logic                 frame_valid,
    output logic                 timeout_err,
    output logic [ERR_CNT_W-1:0] overrun_cnt,
    output logic [ERR_CNT_W-1:0] miss_cnt
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              start_q, start_d;
    logic              rx_bit_valid_q, rx_bit_valid_d;
    logic              rx_bit_q, rx_bit_d;
    logic              pkt_done_q, pkt_done_d;
    logic              busy_q, busy_d;
    logic              frame_valid_q, frame_valid_d;
    logic              timeout_err_q, timeout_err_d;
    logic              overrun_inc;
    logic              miss_inc;

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        bit_cnt_d      = bit_cnt_q;
        idle_d         = idle_q;
        rx_bit_valid_d = 1'b0;
        rx_bit_d       = 1'b0;
        timeout_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && trigger) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    len_d     = CNT_W'(clamp_len(int'(cfg_frame_bits), MAX_BITS));
                    bit_cnt_d = '0;
                    idle_d    = '0;
                    state_d   = RECV;
                end
            end
            RECV: begin
                // Abort wins over a bit arriving in the same cycle.
                if (!enable) begin
                    state_d = IDLE;
                end else if (rx_bit_valid_in) begin
                    rx_bit_valid_d = 1'b1;
                    rx_bit_d       = rx_bit_in;
                    bit_cnt_d      = bit_cnt_q + CNT_W'(1);
                    idle_d         = '0;
                    if (bit_cnt_q == len_q - CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end else if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_d    = (state_d == CLEAR);
        busy_d     = (state_d != IDLE);
        pkt_done_d = (state_q == DONE);

        // A capture always leaves a frame pending, even if the old one is acked at the same time.
        frame_valid_d = frame_valid_q;
        if (pkt_done_q) begin
            frame_valid_d = 1'b1;
        end else if (frame_ack) begin
            frame_valid_d = 1'b0;
        end

        overrun_inc = pkt_done_q && frame_valid_q && !frame_ack;
        miss_inc    = trigger && (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            len_q          <= '0;
            bit_cnt_q      <= '0;
            idle_q         <= '0;
            start_q        <= 1'b0;
            rx_bit_valid_q <= 1'b0;
            rx_bit_q       <= 1'b0;
            pkt_done_q     <= 1'b0;
            busy_q         <= 1'b0;
            frame_valid_q  <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            bit_cnt_q      <= bit_cnt_d;
            idle_q         <= idle_d;
            start_q        <= start_d;
            rx_bit_valid_q <= rx_bit_valid_d;
            rx_bit_q       <= rx_bit_d;
            pkt_done_q     <= pkt_done_d;
            busy_q         <= busy_d;
            frame_valid_q  <= frame_valid_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    sat_counter #(.WIDTH(ERR_CNT_W)) u_overrun_cnt (
        .clk (clk),
        .rst (rst),
        .inc (overrun_inc),
        .q   (overrun_cnt)
    );

    sat_counter #(.WIDTH(ERR_CNT_W)) u_miss_cnt (
        .clk (clk),
        .rst (rst),
        .inc (miss_inc),
        .q   (miss_cnt)
    );

    assign start        = start_q;
    assign rx_bit_valid = rx_bit_valid_q;
    assign rx_bit       = rx_bit_q;
    assign pkt_done     = pkt_done_q;
    assign busy         = busy_q;
    assign frame_valid  = frame_valid_q;
    assign timeout_err  = timeout_err_q;

endmodule
